lshift4_sat_stream: RTL

Streaming fixed-point rescaler that multiplies each signed element by 2^SHIFT (default SHIFT=4), i.e. an arithmetic left shift with saturation. It is the inverse of the attention head's 4-bit arithmetic right-shift stage and restores the scale of attention-score vectors before the next matmul core. It carries a valid/ready handshake with a one-entry skid buffer, so it sustains full throughput under back-pressure.

---
 rtl/lshift4_sat_stream_if.sv | 24 ++
 rtl/lshift4_sat_stream.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lshift4_sat_stream_if.sv
// Handshake bundle for lshift4_sat_stream: input beat stream, output beat stream
// and the per-word saturation flags that travel with each output beat.
interface lshift4_sat_stream_if #(
  parameter int VECTOR_BITS   = 512,
  parameter int TOTAL_INPUT_W = 2
);
  logic [VECTOR_BITS-1:0]   in_data  [TOTAL_INPUT_W];
  logic                     in_valid;
  logic                     in_ready;
  logic [VECTOR_BITS-1:0]   out_data [TOTAL_INPUT_W];
  logic                     out_valid;
  logic                     out_ready;
  logic [TOTAL_INPUT_W-1:0] out_sat;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sat
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sat
  );
endinterface

// File: rtl/lshift4_sat_stream.sv
// Saturating arithmetic left shift (x * 2^SHIFT) on a valid/ready stream with a one-entry skid buffer.
// Optional saturated-element counter enabled by defining LSHIFT_SAT_COUNT_EN.
module lshift4_sat_stream #(
  parameter int WIDTH_OUT     = 16,
  parameter int CHUNK_SIZE    = 4,
  parameter int NUM_CORES_A   = 4,
  parameter int NUM_CORES_B   = 1,
  parameter int TOTAL_MODULES = 2,
  parameter int TOTAL_INPUT_W = 2,
  parameter int SHIFT         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  lshift4_sat_stream_if.slave s
`ifdef LSHIFT_SAT_COUNT_EN
  ,
  output logic [31:0]         sat_count
`endif
);
  localparam int ELEMENTS_PER_VEC = CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES;
  localparam int VECTOR_BITS      = WIDTH_OUT * ELEMENTS_PER_VEC;
  localparam int NUM_ELEMS        = TOTAL_INPUT_W * ELEMENTS_PER_VEC;
  localparam logic [WIDTH_OUT-1:0] SAT_MAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
  localparam logic [WIDTH_OUT-1:0] SAT_MIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};

  typedef logic [VECTOR_BITS-1:0] word_t;
  // State encoding is {OR.valid, SK.valid}; (0,1) cannot occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  logic [TOTAL_INPUT_W*VECTOR_BITS-1:0] res_flat;
  logic [NUM_ELEMS-1:0]                 elem_sat;
  word_t                                shifted [TOTAL_INPUT_W];
  logic [TOTAL_INPUT_W-1:0]             shifted_sat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_elem
      localparam int W  = gi / ELEMENTS_PER_VEC;
      localparam int E  = gi % ELEMENTS_PER_VEC;
      localparam int HI = VECTOR_BITS - E * WIDTH_OUT - 1;
      logic [WIDTH_OUT-1:0] x;
      logic [SHIFT:0]       top;
      assign x   = s.in_data[W][HI -: WIDTH_OUT];
      // The shift is lossless only when every bit shifted out matches the new sign bit.
      assign top = x[WIDTH_OUT-1 -: SHIFT+1];
      assign elem_sat[gi] = !((&top) || !(|top));
      assign res_flat[W*VECTOR_BITS + HI -: WIDTH_OUT] =
        !elem_sat[gi] ? (x << SHIFT) : (x[WIDTH_OUT-1] ? SAT_MIN : SAT_MAX);
    end

    for (gi = 0; gi < TOTAL_INPUT_W; gi++) begin : g_word
      assign shifted[gi]     = res_flat[gi*VECTOR_BITS +: VECTOR_BITS];
      assign shifted_sat[gi] = |elem_sat[gi*ELEMENTS_PER_VEC +: ELEMENTS_PER_VEC];
    end
  endgenerate

  state_t                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  word_t                    or_data_q [TOTAL_INPUT_W];
  word_t                    or_data_d [TOTAL_INPUT_W];
  word_t                    sk_data_q [TOTAL_INPUT_W];
  word_t                    sk_data_d [TOTAL_INPUT_W];
  logic [TOTAL_INPUT_W-1:0] or_sat_q, or_sat_d, sk_sat_q, sk_sat_d;
  logic                     in_xfer;

  assign in_xfer = s.in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    or_data_d = or_data_q;
    or_sat_d  = or_sat_q;
    sk_data_d = sk_data_q;
    sk_sat_d  = sk_sat_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          or_data_d = shifted;
          or_sat_d  = shifted_sat;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_xfer && s.out_ready) begin
          or_data_d = shifted;
          or_sat_d  = shifted_sat;
        end else if (in_xfer) begin
          sk_data_d = shifted;
          sk_sat_d  = shifted_sat;
          state_d   = FULL;
        end else if (s.out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (s.out_ready) begin
          or_data_d = sk_data_q;
          or_sat_d  = sk_sat_q;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Registered ready: next cycle accepts only if the skid slot is free.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      or_sat_q   <= '0;
      sk_sat_q   <= '0;
      for (int w = 0; w < TOTAL_INPUT_W; w++) begin
        or_data_q[w] <= '0;
        sk_data_q[w] <= '0;
      end
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      or_sat_q   <= or_sat_d;
      sk_sat_q   <= sk_sat_d;
      or_data_q  <= or_data_d;
      sk_data_q  <= sk_data_d;
    end
  end

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = state_q[1];
  assign s.out_data  = or_data_q;
  assign s.out_sat   = or_sat_q;

`ifdef LSHIFT_SAT_COUNT_EN
  localparam int CNT_W = $clog2(NUM_ELEMS + 1);
  logic [CNT_W-1:0] beat_sat_cnt;
  logic [32:0]      sat_sum;
  logic [31:0]      sat_count_q, sat_count_d;

  always_comb begin
    beat_sat_cnt = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      beat_sat_cnt = beat_sat_cnt + CNT_W'(elem_sat[i]);
    end
    sat_sum     = {1'b0, sat_count_q} + 33'(beat_sat_cnt);
    sat_count_d = sat_count_q;
    // Sticks at all-ones instead of wrapping.
    if (in_xfer) begin
      sat_count_d = sat_sum[32] ? '1 : sat_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`endif
endmodule
